// File: rtl/axis_window_acc.sv
// AXI4-Stream window accumulator: merges cfg_length accepted beats into one output beat,
// combining the low MASK_WIDTH bits by OR/AND/XOR and keeping the first beat's upper bits.
module axis_window_acc #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned MASK_WIDTH = 66,
  parameter int unsigned CNTR_WIDTH = 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [CNTR_WIDTH-1:0] cfg_length,
  input  logic [1:0]            cfg_mode,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [31:0]           win_count
);

  // Shifting by DATA_WIDTH yields zero, so a full-width mask needs no special case.
  localparam logic [DATA_WIDTH-1:0] LowMask = ~({DATA_WIDTH{1'b1}} << MASK_WIDTH);

  typedef enum logic [0:0] {StIdle, StAcc} state_e;

  state_e                  state_q, state_d;
  logic [CNTR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNTR_WIDTH-1:0]   len_q, len_d;
  logic [1:0]              mode_q, mode_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [DATA_WIDTH-1:0]   m_tdata_q, m_tdata_d;
  logic                    m_tvalid_q, m_tvalid_d;
  logic [31:0]             win_count_q, win_count_d;

  logic [CNTR_WIDTH-1:0]   cnt_inc;
  logic                    closing;
  logic                    s_ready;
  logic                    accept;
  logic                    close;
  logic [DATA_WIDTH-1:0]   op_res;
  logic [DATA_WIDTH-1:0]   merged;
  logic [DATA_WIDTH-1:0]   close_data;

  always_comb begin
    cnt_inc = cnt_q + 1'b1;
    // In idle the window length comes straight from cfg, since it is latched on this beat.
    closing = (state_q == StIdle) ? (cfg_length <= CNTR_WIDTH'(1)) : (cnt_inc == len_q);
    s_ready = ~areset & (~closing | ~m_tvalid_q | m_axis_tready);
    accept  = s_axis_tvalid & s_ready;

    case (mode_q)
      2'd1:    op_res = acc_q & s_axis_tdata;
      2'd2:    op_res = acc_q ^ s_axis_tdata;
      default: op_res = acc_q | s_axis_tdata;
    endcase
    merged = (acc_q & ~LowMask) | (op_res & LowMask);

    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    m_tdata_d   = m_tdata_q;
    m_tvalid_d  = m_tvalid_q;
    win_count_d = win_count_q;
    close       = 1'b0;
    close_data  = merged;

    if (accept) begin
      if (state_q == StIdle) begin
        len_d  = cfg_length;
        mode_d = cfg_mode;
        acc_d  = s_axis_tdata;
        if (closing) begin
          close      = 1'b1;
          close_data = s_axis_tdata;
          cnt_d      = '0;
        end else begin
          cnt_d   = CNTR_WIDTH'(1);
          state_d = StAcc;
        end
      end else begin
        acc_d = merged;
        if (closing) begin
          close   = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    end

    if (m_tvalid_q & m_axis_tready) m_tvalid_d = 1'b0;
    // A closing window reloads the output register even while the old result is being taken.
    if (close) begin
      m_tdata_d   = close_data;
      m_tvalid_d  = 1'b1;
      win_count_d = win_count_q + 32'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      len_q       <= '0;
      mode_q      <= '0;
      acc_q       <= '0;
      m_tdata_q   <= '0;
      m_tvalid_q  <= 1'b0;
      win_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      m_tdata_q   <= m_tdata_d;
      m_tvalid_q  <= m_tvalid_d;
      win_count_q <= win_count_d;
    end
  end

  assign s_axis_tready = s_ready;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign win_count     = win_count_q;

endmodule

// File: tb/tb_axis_window_acc.sv
// Directed bench for axis_window_acc: a table of whole windows plus hand-written sequences
// for pass-through, backpressure, mid-window config change and reset.
module tb_axis_window_acc;

  localparam int unsigned DW = 128;
  localparam int unsigned CW = 8;

  logic          aclk = 1'b0;
  logic          areset;
  logic [CW-1:0] cfg_length;
  logic [1:0]    cfg_mode;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic [31:0]   win_count;

  axis_window_acc #(
    .DATA_WIDTH(128),
    .MASK_WIDTH(66),
    .CNTR_WIDTH(8)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .cfg_length    (cfg_length),
    .cfg_mode      (cfg_mode),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .win_count     (win_count)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_wc = 32'd0;

  typedef struct {
    logic [CW-1:0] len;
    logic [1:0]    mode;
    int            n;
    logic [DW-1:0] beats [4];
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [DW-1:0] mk(input logic [61:0] u, input logic [65:0] l);
    return {u, l};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Present one beat at the falling edge, wait (bounded) for ready, let it be taken.
  task automatic send(input logic [DW-1:0] d, output int waited);
    @(negedge aclk);
    s_tvalid = 1'b1;
    s_tdata  = d;
    waited   = 0;
    #1;
    while (!s_tready && waited < 50) begin
      @(negedge aclk);
      #1;
      waited++;
    end
    if (waited >= 50) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got ready=0 for 50 cycles expected ready=1");
    end
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [DW-1:0] d;

    vecs[0].len = 8'd4; vecs[0].mode = 2'd0; vecs[0].n = 4;
    vecs[0].beats[0] = mk(62'hA, 66'h1); vecs[0].beats[1] = mk(62'hB, 66'h2);
    vecs[0].beats[2] = mk(62'hB, 66'h4); vecs[0].beats[3] = mk(62'hB, 66'h8);
    vecs[0].exp = mk(62'hA, 66'hF);
    vecs[1].len = 8'd3; vecs[1].mode = 2'd1; vecs[1].n = 3;
    vecs[1].beats[0] = mk(62'h1, 66'hFF); vecs[1].beats[1] = mk(62'h2, 66'h0F);
    vecs[1].beats[2] = mk(62'h3, 66'h3C); vecs[1].beats[3] = '0;
    vecs[1].exp = mk(62'h1, 66'h0C);
    vecs[2].len = 8'd3; vecs[2].mode = 2'd2; vecs[2].n = 3;
    vecs[2].beats[0] = mk(62'h5, 66'h5); vecs[2].beats[1] = mk(62'h6, 66'h5);
    vecs[2].beats[2] = mk(62'h7, 66'h1); vecs[2].beats[3] = '0;
    vecs[2].exp = mk(62'h5, 66'h1);
    vecs[3].len = 8'd2; vecs[3].mode = 2'd3; vecs[3].n = 2;
    vecs[3].beats[0] = mk(62'hC, 66'h2_0000_0000_0000_0001);
    vecs[3].beats[1] = mk(62'hD, 66'h1_0000_0000_0000_0000);
    vecs[3].beats[2] = '0; vecs[3].beats[3] = '0;
    vecs[3].exp = mk(62'hC, 66'h3_0000_0000_0000_0001);
    vecs[4].len = 8'd2; vecs[4].mode = 2'd1; vecs[4].n = 2;
    vecs[4].beats[0] = mk(62'h3, 66'h3_FFFF_FFFF_FFFF_FFFF);
    vecs[4].beats[1] = mk(62'h0, 66'h2_0000_0000_0000_0000);
    vecs[4].beats[2] = '0; vecs[4].beats[3] = '0;
    vecs[4].exp = mk(62'h3, 66'h2_0000_0000_0000_0000);

    areset = 1'b1; cfg_length = 8'd4; cfg_mode = 2'd0;
    s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_ready", s_tready, 0);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_wcount", win_count, 0);
    @(negedge aclk);
    areset = 1'b0;

    // Table of complete windows
    for (int v = 0; v < 5; v++) begin
      cfg_length = vecs[v].len;
      cfg_mode   = vecs[v].mode;
      for (int b = 0; b < vecs[v].n; b++) begin
        send(vecs[v].beats[b], w);
        if (b < vecs[v].n - 1) chk("tbl_busy", m_tvalid, 0);
      end
      exp_wc++;
      chk("tbl_tvalid", m_tvalid, 1);
      chk("tbl_tdata", m_tdata, vecs[v].exp);
      chk("tbl_wcount", win_count, exp_wc);
      @(posedge aclk);
      #1;
      chk("tbl_drained", m_tvalid, 0);
    end

    // Pass-through with len 0, then len 1, back-to-back
    cfg_length = 8'd0;
    cfg_mode   = 2'd0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) cfg_length = 8'd1;
      d = mk(62'(i + 16), 66'(i * 3 + 1));
      send(d, w);
      exp_wc++;
      chk("pt_ready", (w == 0), 1);
      chk("pt_tvalid", m_tvalid, 1);
      chk("pt_tdata", m_tdata, d);
    end
    chk("pt_wcount", win_count, exp_wc);
    @(posedge aclk);
    #1;
    chk("pt_drained", m_tvalid, 0);

    // Backpressure: hold first result, stall the closing beat of the second window
    cfg_length = 8'd2;
    m_tready   = 1'b0;
    send(mk(62'h1, 66'h1), w);
    send(mk(62'h2, 66'h2), w);
    exp_wc++;
    chk("bp_w1_tvalid", m_tvalid, 1);
    chk("bp_w1_tdata", m_tdata, mk(62'h1, 66'h3));
    send(mk(62'h3, 66'h4), w);
    chk("bp_b3_ready", (w == 0), 1);
    @(negedge aclk);
    s_tvalid = 1'b1;
    s_tdata  = mk(62'h4, 66'h8);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_stall", s_tready, 0);
      chk("bp_hold_tdata", m_tdata, mk(62'h1, 66'h3));
      chk("bp_hold_tvalid", m_tvalid, 1);
      @(negedge aclk);
    end
    m_tready = 1'b1;
    #1;
    chk("bp_release_ready", s_tready, 1);
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    exp_wc++;
    chk("bp_w2_tvalid", m_tvalid, 1);
    chk("bp_w2_tdata", m_tdata, mk(62'h3, 66'hC));
    chk("bp_w2_wcount", win_count, exp_wc);
    @(posedge aclk);
    #1;
    chk("bp_drained", m_tvalid, 0);

    // Length change mid-window only affects the next window
    cfg_length = 8'd2;
    cfg_mode   = 2'd0;
    send(mk(62'h5, 66'h1), w);
    cfg_length = 8'd5;
    send(mk(62'h6, 66'h2), w);
    exp_wc++;
    chk("cfg_w1_tvalid", m_tvalid, 1);
    chk("cfg_w1_tdata", m_tdata, mk(62'h5, 66'h3));
    for (int i = 0; i < 5; i++) begin
      send(mk(62'(i + 7), 66'(1 << i)), w);
      if (i == 3) chk("cfg_w2_busy", m_tvalid, 0);
    end
    exp_wc++;
    chk("cfg_w2_tvalid", m_tvalid, 1);
    chk("cfg_w2_tdata", m_tdata, mk(62'h7, 66'h1F));
    chk("cfg_w2_wcount", win_count, exp_wc);
    @(posedge aclk);

    // Reset mid-window discards it; next four beats form a clean window
    cfg_length = 8'd4;
    send(mk(62'h9, 66'h10), w);
    send(mk(62'h9, 66'h20), w);
    @(negedge aclk);
    areset = 1'b1;
    #1;
    chk("mr_ready", s_tready, 0);
    @(posedge aclk);
    #1;
    chk("mr_tvalid", m_tvalid, 0);
    chk("mr_tdata", m_tdata, 0);
    chk("mr_wcount", win_count, 0);
    @(negedge aclk);
    areset = 1'b0;
    send(mk(62'h1, 66'h1), w);
    send(mk(62'h2, 66'h2), w);
    send(mk(62'h3, 66'h4), w);
    chk("mr_busy", m_tvalid, 0);
    send(mk(62'h4, 66'h8), w);
    chk("mr_tvalid2", m_tvalid, 1);
    chk("mr_tdata2", m_tdata, mk(62'h1, 66'hF));
    chk("mr_wcount2", win_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
